// File: rtl/regfile_wb_arbiter.sv
// Write-port scheduler and load hazard scoreboard for a single-write-port register file.
// Load returns always win the write port. An ALU result that loses to a load is parked
// in a one-entry hold register and written on the next load-free cycle. A bit per
// register tracks in-flight load destinations so decode can stall on RAW/WAW hazards.
module regfile_wb_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_LOADS     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   // ALU writeback source (stallable)
   input  logic                     alu_valid_i,
   output logic                     alu_ready_o,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd_i,
   input  logic [DATA_WIDTH-1:0]    alu_wd_i,
   // Load issue tracking
   input  logic                     ld_issue_i,
   input  logic [ADDRESS_WIDTH-1:0] ld_issue_rd_i,
   output logic                     ld_issue_ready_o,
   // Load return (cannot be back-pressured)
   input  logic                     ld_valid_i,
   input  logic [ADDRESS_WIDTH-1:0] ld_rd_i,
   input  logic [DATA_WIDTH-1:0]    ld_wd_i,
   // Decode-stage hazard check
   input  logic [ADDRESS_WIDTH-1:0] rs1_i,
   input  logic [ADDRESS_WIDTH-1:0] rs2_i,
   input  logic [ADDRESS_WIDTH-1:0] rd_i,
   output logic                     stall_o,
   // Register-file write port
   output logic                     WE3,
   output logic [ADDRESS_WIDTH-1:0] AD3,
   output logic [DATA_WIDTH-1:0]    WD3,
   // Sticky protocol error
   output logic                     err_o
);

   localparam int NUM_REGS = 1 << ADDRESS_WIDTH;
   localparam int CNT_W    = $clog2(MAX_LOADS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);
   localparam logic [ADDRESS_WIDTH-1:0] REG_ZERO = '0;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } hold_state_t;

   // Hold FSM and its registered ready output
   hold_state_t               r_state;
   logic                      r_alu_ready;
   logic [ADDRESS_WIDTH-1:0]  r_hold_rd;
   logic [DATA_WIDTH-1:0]     r_hold_wd;

   // Load tracking
   logic [CNT_W-1:0]          r_ld_count;
   logic [NUM_REGS-1:0]       r_pending;
   logic                      r_err;

   // Write port registers
   logic                      r_we;
   logic [ADDRESS_WIDTH-1:0]  r_ad;
   logic [DATA_WIDTH-1:0]     r_wd;

   // Combinational helpers
   logic                      w_alu_accept;
   logic                      w_issue_ok;
   logic                      w_sel_valid;
   logic [ADDRESS_WIDTH-1:0]  w_sel_rd;
   logic [DATA_WIDTH-1:0]     w_sel_wd;
   logic [NUM_REGS-1:0]       w_pending_next;
   logic                      w_rs1_hz;
   logic                      w_rs2_hz;
   logic                      w_waw_hz;

   // ALU handshake completes only while the hold register is empty
   assign w_alu_accept = alu_valid_i & r_alu_ready;

   // An issue at full capacity is dropped unless a return frees a slot the same cycle
   assign w_issue_ok = ld_issue_i & ((r_ld_count < CNT_MAX) | ld_valid_i);

   // Write-source selection: load return, then held ALU result, then fresh ALU result
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it
      // unassigned; a missing default would infer a latch.
      w_sel_valid = 1'b0;
      w_sel_rd    = '0;
      w_sel_wd    = '0;
      if (ld_valid_i) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = ld_rd_i;
         w_sel_wd    = ld_wd_i;
      end else if (r_state == ST_FULL) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = r_hold_rd;
         w_sel_wd    = r_hold_wd;
      end else if (w_alu_accept) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = alu_rd_i;
         w_sel_wd    = alu_wd_i;
      end
   end

   // Next scoreboard value: clear the returning index, then set the issued one so set wins
   always_comb begin
      w_pending_next = r_pending;
      if (ld_valid_i)
         w_pending_next[ld_rd_i] = 1'b0;
      if (w_issue_ok && (ld_issue_rd_i != REG_ZERO))
         w_pending_next[ld_issue_rd_i] = 1'b1;
   end

   // Hazard detection against in-flight loads and the parked ALU result
   assign w_rs1_hz = (rs1_i != REG_ZERO) &
                     (r_pending[rs1_i] | ((r_state == ST_FULL) & (r_hold_rd == rs1_i)));
   assign w_rs2_hz = (rs2_i != REG_ZERO) &
                     (r_pending[rs2_i] | ((r_state == ST_FULL) & (r_hold_rd == rs2_i)));
   assign w_waw_hz = (rd_i != REG_ZERO) & r_pending[rd_i];
   assign stall_o  = w_rs1_hz | w_rs2_hz | w_waw_hz;

   // Hold FSM: park an accepted ALU result that collides with a load return
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_alu_ready <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of block evaluation order.
         case (r_state)
            ST_EMPTY: begin
               if (w_alu_accept && ld_valid_i) begin
                  r_state     <= ST_FULL;
                  r_alu_ready <= 1'b0;
               end
            end
            ST_FULL: begin
               if (!ld_valid_i) begin
                  r_state     <= ST_EMPTY;
                  r_alu_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_alu_ready <= 1'b1;
            end
         endcase
      end
   end

   // Hold payload capture on entry to FULL
   always_ff @(posedge clk) begin
      // NOTE: pure datapath storage is left unreset; it is only observed while the
      // FSM says FULL, and the FSM itself is reset.
      if ((r_state == ST_EMPTY) && w_alu_accept && ld_valid_i) begin
         r_hold_rd <= alu_rd_i;
         r_hold_wd <= alu_wd_i;
      end
   end

   // Outstanding-load counter and sticky underflow error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ld_count <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_issue_ok && !ld_valid_i) begin
            r_ld_count <= r_ld_count + 1'b1;
         end else if (!w_issue_ok && ld_valid_i && (r_ld_count != '0)) begin
            r_ld_count <= r_ld_count - 1'b1;
         end
         if (ld_valid_i && (r_ld_count == '0))
            r_err <= 1'b1;
      end
   end

   // Pending-destination scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_pending <= '0;
      else
         r_pending <= w_pending_next;
   end

   // Registered register-file write port; writes to x0 are suppressed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we <= 1'b0;
         r_ad <= '0;
         r_wd <= '0;
      end else begin
         r_we <= w_sel_valid & (w_sel_rd != REG_ZERO);
         if (w_sel_valid) begin
            r_ad <= w_sel_rd;
            r_wd <= w_sel_wd;
         end
      end
   end

   assign alu_ready_o      = r_alu_ready;
   assign ld_issue_ready_o = (r_ld_count < CNT_MAX);
   assign WE3              = r_we;
   assign AD3              = r_ad;
   assign WD3              = r_wd;
   assign err_o            = r_err;

endmodule
